// File: rtl/usbh_report_decoder_generic.sv
// usbh_report_decoder_generic: HID gamepad report to NES button byte with analog hysteresis, SOCD, autofire and stale timeout
module usbh_report_decoder_generic #(
  parameter int              C_CLK_HZ      = 48000000,
  parameter int              C_AUTOFIRE_HZ = 10,
  parameter int              C_REPORT_BITS = 160,
  parameter logic [63:0]     C_BTN_IDX     = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter logic [15:0]     C_TURBO_IDX   = 16'hFFFF,
  parameter int              C_AXIS_BITS   = 8,
  parameter int              C_X_LSB       = 56,
  parameter int              C_Y_LSB       = 72,
  parameter int              C_AXIS_SIGNED = 1,
  parameter int              C_ON_LO       = 64,
  parameter int              C_OFF_LO      = 96,
  parameter int              C_OFF_HI      = 160,
  parameter int              C_ON_HI       = 192,
  parameter int              C_SOCD        = 1,
  parameter int              C_TIMEOUT_MS  = 100
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [C_REPORT_BITS-1:0] i_report,
  input  logic                     i_report_valid,
  input  logic [1:0]               i_autofire_en,
  output logic [7:0]               o_btn,
  output logic                     o_stale
);
  localparam int TO_CYC = C_CLK_HZ / 1000 * C_TIMEOUT_MS;
  localparam int AF_MAX = C_CLK_HZ / (2 * C_AUTOFIRE_HZ) - 1;
  localparam int TW = $clog2(TO_CYC + 1);
  localparam int AW = $clog2(AF_MAX + 2);
  localparam int W = C_AXIS_BITS;
  localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TO_CYC);
  localparam logic [AW-1:0] AF_LAST = AW'(AF_MAX);
  localparam logic [W-1:0] ON_LO = W'(C_ON_LO);
  localparam logic [W-1:0] OFF_LO = W'(C_OFF_LO);
  localparam logic [W-1:0] OFF_HI = W'(C_OFF_HI);
  localparam logic [W-1:0] ON_HI = W'(C_ON_HI);
  localparam logic [W-1:0] FLIP = (C_AXIS_SIGNED != 0) ? {1'b1, {(W-1){1'b0}}} : '0;
  typedef enum logic [1:0] {CENTER, NEG, POS} axis_t;
  function automatic axis_t axis_step(input axis_t s, input logic [W-1:0] u);
    return (s == CENTER) ? ((u <= ON_LO) ? NEG : (u >= ON_HI) ? POS : CENTER) :
           (s == NEG)    ? ((u >= ON_HI) ? POS : (u >= OFF_LO) ? CENTER : NEG) :
                           ((u <= ON_LO) ? NEG : (u <= OFF_HI) ? CENTER : POS);
  endfunction
  // Report is zero-padded to 256 bits, so index 8'hFF (unmapped) always reads 0.
  logic [255:0] rp;
  logic [7:0] dig, btn_r, btn_nx;
  logic [1:0] turbo_r;
  logic [W-1:0] xu, yu;
  axis_t x_st, y_st;
  logic [TW-1:0] tcnt;
  logic [AW-1:0] af_cnt;
  logic phase, l, r, u, d;
  assign rp = 256'(i_report);
  assign xu = i_report[C_X_LSB +: W] ^ FLIP;
  assign yu = i_report[C_Y_LSB +: W] ^ FLIP;
  always_comb for (int k = 0; k < 8; k++) dig[k] = rp[C_BTN_IDX[8*k +: 8]];
  assign l = btn_r[6] | (x_st == NEG);
  assign r = btn_r[7] | (x_st == POS);
  assign u = btn_r[4] | (y_st == NEG);
  assign d = btn_r[5] | (y_st == POS);
  assign btn_nx = {(C_SOCD != 0) ? r & ~l : r,
                   (C_SOCD != 0) ? l & ~r : l,
                   (C_SOCD != 0) ? d & ~u : d,
                   (C_SOCD != 0) ? u & ~d : u,
                   btn_r[3:2],
                   btn_r[1] | (turbo_r[1] & phase & i_autofire_en[1]),
                   btn_r[0] | (turbo_r[0] & phase & i_autofire_en[0])};
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_btn <= '0;
      o_stale <= 1'b0;
      btn_r <= '0;
      turbo_r <= '0;
      x_st <= CENTER;
      y_st <= CENTER;
      tcnt <= '0;
      af_cnt <= '0;
      phase <= 1'b0;
    end else begin
      af_cnt <= (af_cnt == AF_LAST) ? '0 : af_cnt + 1'b1;
      phase <= (af_cnt == AF_LAST) ? ~phase : phase;
      o_btn <= btn_nx;
      if (i_report_valid) begin
        tcnt <= '0;
        o_stale <= 1'b0;
        btn_r <= dig;
        turbo_r <= {rp[C_TURBO_IDX[15:8]], rp[C_TURBO_IDX[7:0]]};
        x_st <= axis_step(x_st, xu);
        y_st <= axis_step(y_st, yu);
      end else if (tcnt >= TO_LAST) begin
        tcnt <= TO_MAX;
        o_stale <= 1'b1;
        btn_r <= '0;
        turbo_r <= '0;
        x_st <= CENTER;
        y_st <= CENTER;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_usbh_report_decoder_generic.sv
// tb_usbh_report_decoder_generic: randomized bench against a behavioural model; two instances cover SOCD on/off and unsigned/signed axes
module tb_usbh_report_decoder_generic;
  localparam int RB = 160;
  localparam logic [63:0] BIDX = {8'd15, 8'd14, 8'd13, 8'd12, 8'd11, 8'hFF, 8'd9, 8'd8};
  localparam logic [RB-1:0] ONE = 160'd1;
  localparam int TO = 40;
  localparam int HALF = 5;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, vld;
  logic [RB-1:0] rep;
  logic [1:0] en;
  logic [7:0] b0, b1;
  logic s0, s1;
  usbh_report_decoder_generic #(.C_CLK_HZ(1000), .C_AUTOFIRE_HZ(100), .C_REPORT_BITS(RB), .C_BTN_IDX(BIDX),
    .C_TURBO_IDX(16'h1110), .C_AXIS_SIGNED(0), .C_SOCD(1), .C_TIMEOUT_MS(TO)) dut0 (
    .i_clk(clk), .i_reset(rst), .i_report(rep), .i_report_valid(vld), .i_autofire_en(en), .o_btn(b0), .o_stale(s0));
  usbh_report_decoder_generic #(.C_CLK_HZ(1000), .C_AUTOFIRE_HZ(100), .C_REPORT_BITS(RB), .C_BTN_IDX(BIDX),
    .C_TURBO_IDX(16'h1110), .C_AXIS_SIGNED(1), .C_SOCD(0), .C_TIMEOUT_MS(TO)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_report(rep), .i_report_valid(vld), .i_autofire_en(en), .o_btn(b1), .o_stale(s1));
  int bidx[8] = '{8, 9, 255, 11, 12, 13, 14, 15};
  int n, idle, ncmp, nfail;
  int mx[2], my[2];
  logic [7:0] m_dig;
  logic [1:0] m_tb;
  logic m_st, e_st;
  logic [7:0] e_btn[2];
  function automatic int axn(input int s, input int u);
    if (s == 0) return (u <= 64) ? -1 : (u >= 192) ? 1 : 0;
    if (s == -1) return (u >= 192) ? 1 : (u >= 96) ? 0 : -1;
    return (u <= 64) ? -1 : (u <= 160) ? 0 : 1;
  endfunction
  function automatic logic [RB-1:0] mk(input logic [7:0] x, input logic [7:0] y, input logic [RB-1:0] ex);
    logic [RB-1:0] v;
    v = ex;
    v[63:56] = x;
    v[79:72] = y;
    return v;
  endfunction
  task automatic cyc(input logic r_i, input logic v_i, input logic [RB-1:0] rp, input logic [1:0] e_i);
    logic ph, l, r, u, d;
    rst = r_i;
    vld = v_i;
    rep = v_i ? rp : {$urandom, $urandom, $urandom, $urandom, $urandom};
    en = e_i;
    if (r_i) begin
      n = 0; idle = 0; m_st = 0; m_dig = 0; m_tb = 0;
      mx = '{0, 0}; my = '{0, 0};
      e_btn[0] = 0; e_btn[1] = 0;
    end else begin
      n++;
      ph = (((n - 1) / HALF) % 2) == 1;
      for (int i = 0; i < 2; i++) begin
        l = m_dig[6] | (mx[i] == -1);
        r = m_dig[7] | (mx[i] == 1);
        u = m_dig[4] | (my[i] == -1);
        d = m_dig[5] | (my[i] == 1);
        if (i == 0 && l && r) begin l = 0; r = 0; end
        if (i == 0 && u && d) begin u = 0; d = 0; end
        e_btn[i] = {r, l, d, u, m_dig[3:2], m_dig[1] | (m_tb[1] & ph & e_i[1]), m_dig[0] | (m_tb[0] & ph & e_i[0])};
      end
      if (v_i) begin
        idle = 0; m_st = 0;
        for (int k = 0; k < 8; k++) m_dig[k] = (bidx[k] == 255) ? 1'b0 : rp[bidx[k]];
        m_tb = {rp[17], rp[16]};
        for (int i = 0; i < 2; i++) begin
          mx[i] = axn(mx[i], int'(rp[63:56]) ^ (i * 128));
          my[i] = axn(my[i], int'(rp[79:72]) ^ (i * 128));
        end
      end else if (idle + 1 >= TO) begin
        idle = TO; m_st = 1; m_dig = 0; m_tb = 0;
        mx = '{0, 0}; my = '{0, 0};
      end else idle++;
    end
    e_st = m_st;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      cyc(1, 1'($urandom), {$urandom, $urandom, $urandom, $urandom, $urandom}, 2'b11);
      if ({b0, s0, b1, s1} !== {e_btn[0], e_st, e_btn[1], e_st}) begin
        nfail++; $display("FAIL reset: got %h %b %h %b want %h %b %h %b", b0, s0, b1, s1, e_btn[0], e_st, e_btn[1], e_st);
      end
      ncmp++;
    end
  endtask
  task automatic test_axis();
    logic [7:0] xs[6] = '{8'h00, 8'h50, 8'h70, 8'h80, 8'hC0, 8'h20};
    logic [7:0] want[6] = '{8'h40, 8'h40, 8'h00, 8'h00, 8'h80, 8'h40};
    for (int j = 0; j < 6; j++) begin
      for (int c = 0; c < 2; c++) begin
        cyc(0, c == 0, mk(xs[j], 8'h80, '0), 2'b00);
        if ({b0, s0, b1, s1} !== {e_btn[0], e_st, e_btn[1], e_st}) begin
          nfail++; $display("FAIL axis: got %h %b %h %b want %h %b %h %b", b0, s0, b1, s1, e_btn[0], e_st, e_btn[1], e_st);
        end
        ncmp++;
      end
      if (b0 !== want[j]) begin
        nfail++; $display("FAIL axis_x%0d: got %h want %h", j, b0, want[j]);
      end
      ncmp++;
    end
  endtask
  task automatic test_socd();
    for (int c = 0; c < 3; c++) begin
      cyc(0, c == 0, mk(8'h80, 8'h80, (ONE << 12) | (ONE << 13) | (ONE << 14) | (ONE << 15)), 2'b00);
      if ({b0, s0, b1, s1} !== {e_btn[0], e_st, e_btn[1], e_st}) begin
        nfail++; $display("FAIL socd: got %h %b %h %b want %h %b %h %b", b0, s0, b1, s1, e_btn[0], e_st, e_btn[1], e_st);
      end
      ncmp++;
    end
    if (b0[7:4] !== 4'b0000 || b1[7:4] !== 4'b1111) begin
      nfail++; $display("FAIL socd_dirs: got %h %h want 0 f", b0[7:4], b1[7:4]);
    end
    ncmp++;
  endtask
  task automatic test_autofire();
    int tog;
    tog = 0;
    for (int c = 0; c < 40; c++) begin
      cyc(0, c % 10 == 0, mk(8'h80, 8'h80, (ONE << 16) | (ONE << 17)), c < 22 ? 2'b01 : c < 28 ? 2'b00 : 2'b10);
      if ({b0, s0, b1, s1} !== {e_btn[0], e_st, e_btn[1], e_st}) begin
        nfail++; $display("FAIL autofire: got %h %b %h %b want %h %b %h %b", b0, s0, b1, s1, e_btn[0], e_st, e_btn[1], e_st);
      end
      ncmp++;
      if (c >= 2 && c < 22 && b0[0] !== ((((n - 1) / HALF) % 2) == 1)) tog++;
    end
    if (tog != 0) begin
      nfail++; $display("FAIL autofire_period: got %0d off-phase cycles want 0", tog);
    end
    ncmp++;
  endtask
  task automatic test_timeout();
    logic [RB-1:0] rp;
    rp = mk(8'h80, 8'h80, ONE << 11);
    for (int c = 0; c < 46; c++) begin
      cyc(0, c == 0, rp, 2'b00);
      if ({b0, s0, b1, s1} !== {e_btn[0], e_st, e_btn[1], e_st}) begin
        nfail++; $display("FAIL timeout: got %h %b %h %b want %h %b %h %b", b0, s0, b1, s1, e_btn[0], e_st, e_btn[1], e_st);
      end
      ncmp++;
    end
    if (s0 !== 1'b1 || b0 !== 8'h00) begin
      nfail++; $display("FAIL timeout_stale: got %b %h want 1 00", s0, b0);
    end
    ncmp++;
    for (int c = 0; c < TO + 2; c++) begin
      cyc(0, c == 0 || c == TO, rp, 2'b00);
      if ({b0, s0, b1, s1} !== {e_btn[0], e_st, e_btn[1], e_st}) begin
        nfail++; $display("FAIL timeout_race: got %h %b %h %b want %h %b %h %b", b0, s0, b1, s1, e_btn[0], e_st, e_btn[1], e_st);
      end
      ncmp++;
    end
    if (s0 !== 1'b0 || b0 !== 8'h08) begin
      nfail++; $display("FAIL timeout_recover: got %b %h want 0 08", s0, b0);
    end
    ncmp++;
  endtask
  task automatic test_reset_mid();
    for (int c = 0; c < 9; c++) begin
      cyc(c == 8, c == 0, mk(8'h00, 8'hC0, (ONE << 8) | (ONE << 16) | (ONE << 17)), 2'b11);
      if ({b0, s0, b1, s1} !== {e_btn[0], e_st, e_btn[1], e_st}) begin
        nfail++; $display("FAIL reset_mid: got %h %b %h %b want %h %b %h %b", b0, s0, b1, s1, e_btn[0], e_st, e_btn[1], e_st);
      end
      ncmp++;
    end
    if ({b0, s0, b1, s1} !== 18'd0) begin
      nfail++; $display("FAIL reset_mid_zero: got %h %b %h %b want 00 0 00 0", b0, s0, b1, s1);
    end
    ncmp++;
  endtask
  task automatic test_random();
    for (int c = 0; c < 700; c++) begin
      cyc($urandom_range(0, 199) == 0, c < 350 ? $urandom_range(0, 2) == 0 : $urandom_range(0, 59) == 0,
          {$urandom, $urandom, $urandom, $urandom, $urandom}, 2'($urandom));
      if ({b0, s0, b1, s1} !== {e_btn[0], e_st, e_btn[1], e_st}) begin
        nfail++; $display("FAIL random: got %h %b %h %b want %h %b %h %b", b0, s0, b1, s1, e_btn[0], e_st, e_btn[1], e_st);
      end
      ncmp++;
    end
  endtask
  initial begin
    ncmp = 0; nfail = 0;
    rst = 1; vld = 0; rep = '0; en = 0;
    test_reset();
    test_axis();
    test_socd();
    test_autofire();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
